// File: rtl/cpu_core_n.sv
`default_nettype none
// cpu_core_n: single-cycle A/B register CPU with carry flag, output latch and absolute/conditional jumps.
// Optional HALT opcode (1000) is enabled by defining CPU_CORE_HALT_EN.
module cpu_core_n #(
  parameter int DATA_W = 4,
  parameter int PC_W   = 4
) (
  input  logic              clk_cpu,
  input  logic              reset,
  input  logic              en,
  input  logic [DATA_W+3:0] inst,
  input  logic [DATA_W-1:0] in_port,
  output logic [PC_W-1:0]   pc,
  output logic [DATA_W-1:0] out_port,
  output logic              carry,
  output logic              halted
);

  localparam logic [3:0] OP_ADD_A  = 4'b0000;
  localparam logic [3:0] OP_ADD_B  = 4'b0101;
  localparam logic [3:0] OP_MOV_A  = 4'b0011;
  localparam logic [3:0] OP_MOV_B  = 4'b0111;
  localparam logic [3:0] OP_A_FR_B = 4'b0001;
  localparam logic [3:0] OP_B_FR_A = 4'b0100;
  localparam logic [3:0] OP_IN_A   = 4'b0010;
  localparam logic [3:0] OP_IN_B   = 4'b0110;
  localparam logic [3:0] OP_OUT_B  = 4'b1001;
  localparam logic [3:0] OP_OUT_IM = 4'b1011;
  localparam logic [3:0] OP_JMP    = 4'b1111;
  localparam logic [3:0] OP_JNC    = 4'b1110;
  localparam logic [3:0] OP_HALT   = 4'b1000;

  logic [DATA_W-1:0] a_reg;
  logic [DATA_W-1:0] b_reg;
  logic [DATA_W-1:0] a_nxt;
  logic [DATA_W-1:0] b_nxt;
  logic [DATA_W-1:0] out_nxt;
  logic [PC_W-1:0]   pc_nxt;
  logic              carry_nxt;
  logic              exec;
  logic [3:0]        opcode;
  logic [DATA_W-1:0] im;
  logic [DATA_W:0]   sum_a;
  logic [DATA_W:0]   sum_b;

  assign opcode = inst[DATA_W+3:DATA_W];
  assign im     = inst[DATA_W-1:0];
  assign sum_a  = {1'b0, a_reg} + {1'b0, im};
  assign sum_b  = {1'b0, b_reg} + {1'b0, im};
  assign exec   = en & ~halted;

`ifdef CPU_CORE_HALT_EN
  logic halt_reg;
  logic halt_nxt;
`endif

  always_comb begin
    a_nxt     = a_reg;
    b_nxt     = b_reg;
    out_nxt   = out_port;
    pc_nxt    = pc + PC_W'(1);
    carry_nxt = 1'b0;
`ifdef CPU_CORE_HALT_EN
    halt_nxt  = halt_reg;
`endif
    case (opcode)
      OP_ADD_A: begin
        a_nxt     = sum_a[DATA_W-1:0];
        carry_nxt = sum_a[DATA_W];
      end
      OP_ADD_B: begin
        b_nxt     = sum_b[DATA_W-1:0];
        carry_nxt = sum_b[DATA_W];
      end
      OP_MOV_A:  a_nxt   = im;
      OP_MOV_B:  b_nxt   = im;
      OP_A_FR_B: a_nxt   = b_reg;
      OP_B_FR_A: b_nxt   = a_reg;
      OP_IN_A:   a_nxt   = in_port;
      OP_IN_B:   b_nxt   = in_port;
      OP_OUT_B:  out_nxt = b_reg;
      OP_OUT_IM: out_nxt = im;
      OP_JMP:    pc_nxt  = im[PC_W-1:0];
      // JNC looks at the carry held before this edge
      OP_JNC: begin
        if (!carry) pc_nxt = im[PC_W-1:0];
      end
      OP_HALT: begin
`ifdef CPU_CORE_HALT_EN
        pc_nxt   = pc;
        halt_nxt = 1'b1;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_cpu or posedge reset) begin
    if (reset) begin
      pc       <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      out_port <= '0;
      carry    <= 1'b0;
    end else if (exec) begin
      pc       <= pc_nxt;
      a_reg    <= a_nxt;
      b_reg    <= b_nxt;
      out_port <= out_nxt;
      carry    <= carry_nxt;
    end
  end

`ifdef CPU_CORE_HALT_EN
  always_ff @(posedge clk_cpu or posedge reset) begin
    if (reset) halt_reg <= 1'b0;
    else if (exec) halt_reg <= halt_nxt;
  end
  assign halted = halt_reg;
`else
  assign halted = 1'b0;
`endif

endmodule
`default_nettype wire
